// File: rtl/exblock_feeder_pkg.sv
// Shared types and constants for the step-classifier feeder.
package exblock_feeder_pkg;

   // Feeder control states
   typedef enum logic [1:0] {
      StUncfg,
      StReady,
      StWait
   } state_e;

   localparam int unsigned NUM_W = 6;

   // Weight register indices as seen on cfg_addr
   localparam logic [2:0] W_THETA1 = 3'd0;
   localparam logic [2:0] W_THETA2 = 3'd1;
   localparam logic [2:0] W_BETA1  = 3'd2;
   localparam logic [2:0] W_BETA2  = 3'd3;
   localparam logic [2:0] W_ALPHA1 = 3'd4;
   localparam logic [2:0] W_ALPHA2 = 3'd5;

   localparam logic [NUM_W-1:0] MASK_FULL = {NUM_W{1'b1}};

endpackage

// File: rtl/step_edge_counter.sv
// Rising-edge step counter: counts captures where the classifier output goes 0 -> 1.
module step_edge_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             capture,
   input  logic             cur,
   input  logic             clr,
   output logic             step_pulse,
   output logic [CNT_W-1:0] step_count
);

   logic             prev_q, prev_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pulse_q, pulse_d;
   logic             rise;

   // Next-state: clear beats a coinciding capture; count saturates but pulse still fires
   always_comb begin
      rise    = capture & cur & ~prev_q;
      prev_d  = prev_q;
      count_d = count_q;
      pulse_d = 1'b0;
      if (clr) begin
         prev_d  = 1'b0;
         count_d = '0;
      end else if (capture) begin
         prev_d = cur;
         if (rise) begin
            pulse_d = 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
               count_d = count_q + 1'b1;
            end
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= 1'b0;
         count_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         count_q <= count_d;
         pulse_q <= pulse_d;
      end
   end

   assign step_pulse = pulse_q;
   assign step_count = count_q;

endmodule

// File: rtl/exblock_feeder.sv
// Feeder for the step classifier: holds weights, issues one sample at a time,
// waits the classifier latency, captures its result and counts steps.
module exblock_feeder
   import exblock_feeder_pkg::*;
#(
   parameter int unsigned PIPE_LAT = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_addr,
   input  logic [7:0]       cfg_wdata,
   output logic             cfg_err,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_x,
   input  logic [7:0]       s_y,
   input  logic             count_clr,
   output logic [7:0]       ex_a,
   output logic [7:0]       ex_b,
   output logic [7:0]       theta1,
   output logic [7:0]       theta2,
   output logic [7:0]       beta1,
   output logic [7:0]       beta2,
   output logic [7:0]       alpha1,
   output logic [7:0]       alpha2,
   input  logic             ex_step,
   output logic             step_pulse,
   output logic [CNT_W-1:0] step_count,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [NUM_W-1:0] mask_q, mask_d;
   logic [7:0]       w_q [NUM_W];
   logic [7:0]       w_d [NUM_W];
   logic [7:0]       ex_a_q, ex_a_d;
   logic [7:0]       ex_b_q, ex_b_d;
   logic [3:0]       lat_cnt_q, lat_cnt_d;
   logic             cfg_err_q, cfg_err_d;
   logic             wr_ok;
   logic             accept;
   logic             capture;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StUncfg;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: leave UNCFG on the edge the last missing weight lands
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StUncfg: if (mask_d == MASK_FULL) state_d = StReady;
         StReady: if (accept)              state_d = StWait;
         StWait:  if (capture)             state_d = StReady;
         default:                          state_d = StUncfg;
      endcase
   end

   // FSM outputs and handshake decode
   always_comb begin
      s_ready = (state_q == StReady);
      busy    = (state_q == StWait);
      accept  = s_ready & s_valid;
      capture = busy & (lat_cnt_q == 4'd1);
   end

   // Datapath next-state: weight writes are locked out while a sample is in flight
   always_comb begin
      wr_ok     = cfg_we & (cfg_addr < 3'(NUM_W)) & (state_q != StWait);
      cfg_err_d = cfg_we & ~wr_ok;
      mask_d    = mask_q;
      for (int i = 0; i < NUM_W; i++) begin
         w_d[i] = w_q[i];
         if (wr_ok && (cfg_addr == 3'(i))) begin
            w_d[i]    = cfg_wdata;
            mask_d[i] = 1'b1;
         end
      end
      ex_a_d    = ex_a_q;
      ex_b_d    = ex_b_q;
      lat_cnt_d = lat_cnt_q;
      if (accept) begin
         ex_a_d    = s_x;
         ex_b_d    = s_y;
         lat_cnt_d = 4'(PIPE_LAT);
      end else if (busy) begin
         lat_cnt_d = lat_cnt_q - 4'd1;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q    <= '0;
         ex_a_q    <= '0;
         ex_b_q    <= '0;
         lat_cnt_q <= '0;
         cfg_err_q <= 1'b0;
         for (int i = 0; i < NUM_W; i++) begin
            w_q[i] <= '0;
         end
      end else begin
         mask_q    <= mask_d;
         ex_a_q    <= ex_a_d;
         ex_b_q    <= ex_b_d;
         lat_cnt_q <= lat_cnt_d;
         cfg_err_q <= cfg_err_d;
         for (int i = 0; i < NUM_W; i++) begin
            w_q[i] <= w_d[i];
         end
      end
   end

   step_edge_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk        (clk),
      .rst        (rst),
      .capture    (capture),
      .cur        (ex_step),
      .clr        (count_clr),
      .step_pulse (step_pulse),
      .step_count (step_count)
   );

   assign cfg_err = cfg_err_q;
   assign ex_a    = ex_a_q;
   assign ex_b    = ex_b_q;
   assign theta1  = w_q[W_THETA1];
   assign theta2  = w_q[W_THETA2];
   assign beta1   = w_q[W_BETA1];
   assign beta2   = w_q[W_BETA2];
   assign alpha1  = w_q[W_ALPHA1];
   assign alpha2  = w_q[W_ALPHA2];

endmodule
